// File: rtl/dmem_responder_if.sv
// Request/acknowledge bus between the CPU core memory port and dmem_responder.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed access latency. One access is
// outstanding at a time; misaligned or out-of-range accesses return err_o.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = $clog2(LATENCY + 1);
    localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;
    localparam bit          LAT1     = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic              ack_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              enter_resp_c;
    logic              cm_we_c;
    logic [31:0]       cm_addr_c;
    logic [31:0]       cm_wdata_c;
    logic              fault_c;
    logic [IDX_W-1:0]  idx_c;

    // Commit view: with single-cycle latency the commit edge is the
    // acceptance edge, so the live inputs are used instead of the captures.
    always_comb begin
        enter_resp_c = 1'b0;
        cm_we_c      = we_q;
        cm_addr_c    = addr_q;
        cm_wdata_c   = wdata_q;
        if (state_q == IDLE) begin
            enter_resp_c = bus.req_i && LAT1;
            cm_we_c      = bus.we_i;
            cm_addr_c    = bus.addr_i;
            cm_wdata_c   = bus.wdata_i;
        end else if (state_q == WAIT) begin
            enter_resp_c = (cnt_q == '0);
        end
    end

    assign fault_c = (cm_addr_c[1:0] != 2'b00) || (cm_addr_c[31:IDX_W+2] != '0);
    assign idx_c   = cm_addr_c[IDX_W+1:2];

    // Handshake FSM, request capture, latency counter and response registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        ready_q <= 1'b0;
                        if (LAT1) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (enter_resp_c) begin
                rdata_q <= (fault_c || cm_we_c) ? 32'd0 : mem[idx_c];
                err_q   <= fault_c;
            end
        end
    end

    // Storage array; not reset, and never written while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp_c && cm_we_c && !fault_c) begin
            mem[idx_c] <= cm_wdata_c;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.ack_o   = ack_q;
    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 2, 4) share the request
// data lines; each has its own request enable and reset.
module tb_dmem_responder;
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int LAT [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  en;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cnt [3] = '{0, 0, 0};
    exp_t sbq [3][$];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.req_i = req & en[0];
    assign bus1.req_i = req & en[1];
    assign bus2.req_i = req & en[2];
    assign bus0.we_i = we;    assign bus1.we_i = we;    assign bus2.we_i = we;
    assign bus0.addr_i = addr; assign bus1.addr_i = addr; assign bus2.addr_i = addr;
    assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;

    logic [2:0]  ready_v;
    logic [2:0]  ack_v;
    logic [2:0]  err_v;
    logic [31:0] rdata_w [3];
    assign ready_v = {bus2.ready_o, bus1.ready_o, bus0.ready_o};
    assign ack_v   = {bus2.ack_o, bus1.ack_o, bus0.ack_o};
    assign err_v   = {bus2.err_o, bus1.err_o, bus0.err_o};
    assign rdata_w[0] = bus0.rdata_o;
    assign rdata_w[1] = bus1.rdata_o;
    assign rdata_w[2] = bus2.rdata_o;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst_n[0]), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_l2 (.clk_i(clk), .rst_i(rst_n[1]), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(4)) u_l4 (.clk_i(clk), .rst_i(rst_n[2]), .bus(bus2));

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest expectation for that responder.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (ack_v[d] === 1'b1) begin
                ack_cnt[d]++;
                if (sbq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack_l%0d: got ack=1 expected ack=0 (cyc %0d)", LAT[d], cyc);
                end else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("ack_cycle_l%0d", LAT[d]), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("rdata_l%0d", LAT[d]), rdata_w[d], e.rdata);
                    chk($sformatf("err_l%0d", LAT[d]), 32'(err_v[d]), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_ready(input logic [2:0] m);
        int n = 0;
        while (((ready_v & m) != m) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready_v & m), 32'(m));
    endtask

    task automatic issue(input logic [2:0] m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input bit push);
        exp_t e;
        wait_ready(m);
        en = m; req = 1'b1; we = w; addr = a; wdata = d;
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (m[i]) begin
                    e.cyc = cyc + LAT[i]; e.rdata = er; e.err = ee;
                    sbq[i].push_back(e);
                end
            end
        end
        @(negedge clk);
        req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
        chk("ready_low_after_accept", 32'(ready_v & m), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 || ready_v != 3'b111) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input logic [2:0] m, input string tag);
        for (int d = 0; d < 3; d++) begin
            if (m[d]) begin
                chk($sformatf("%s_ready_l%0d", tag, LAT[d]), 32'(ready_v[d]), 32'd1);
                chk($sformatf("%s_ack_l%0d", tag, LAT[d]), 32'(ack_v[d]), 32'd0);
                chk($sformatf("%s_rdata_l%0d", tag, LAT[d]), rdata_w[d], 32'd0);
                chk($sformatf("%s_err_l%0d", tag, LAT[d]), 32'(err_v[d]), 32'd0);
            end
        end
    endtask

    int ack_base [3];
    localparam int B2B_ACKS [3] = '{6, 4, 3};

    initial begin
        rst_n = 3'b000; en = 3'b111;
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0;

        // Reset held with random inputs
        repeat (4) begin
            @(negedge clk);
            req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        chk_reset_outputs(3'b111, "reset");
        req = 1'b0;
        rst_n = 3'b111;
        repeat (5) @(negedge clk);
        chk("no_ack_after_release", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 32'd0);

        // Store / load, misaligned, out of range
        issue(3'b111, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        issue(3'b111, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("rdata_hold_l%0d", LAT[d]), rdata_w[d], 32'hDEADBEEF);
        issue(3'b111, 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1, 1'b1);
        issue(3'b111, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(3'b111, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(3'b111, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(3'b111, 1'b1, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        issue(3'b111, 1'b0, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();

        // Back-to-back: preload 0x40.., then hold req with a new address each cycle
        for (int k = 0; k < 12; k++)
            issue(3'b111, 1'b1, 32'h40 + 32'(4 * k), 32'hB0B0_0000 + 32'(k), 32'h0, 1'b0, 1'b1);
        drain();
        wait_ready(3'b111);
        for (int d = 0; d < 3; d++) ack_base[d] = ack_cnt[d];
        en = 3'b111;
        for (int k = 0; k < 12; k++) begin
            exp_t e;
            req = 1'b1; we = 1'b0; addr = 32'h40 + 32'(4 * k); wdata = $urandom;
            for (int d = 0; d < 3; d++) begin
                if ((k % (LAT[d] + 1)) == 0) begin
                    e.cyc = cyc + LAT[d]; e.rdata = 32'hB0B0_0000 + 32'(k); e.err = 1'b0;
                    sbq[d].push_back(e);
                end
            end
            @(negedge clk);
        end
        req = 1'b0;
        drain();
        for (int d = 0; d < 3; d++)
            chk($sformatf("b2b_ack_count_l%0d", LAT[d]), 32'(ack_cnt[d] - ack_base[d]), 32'(B2B_ACKS[d]));

        // Reset during WAIT drops the pending store (L2, L4)
        issue(3'b111, 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 1'b1);
        issue(3'b111, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();
        issue(3'b110, 1'b1, 32'h20, 32'h11112222, 32'h0, 1'b0, 1'b0);
        rst_n = 3'b001;
        #1;
        chk_reset_outputs(3'b110, "midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 3'b111;
        issue(3'b111, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, 1'b1);
        drain();

        // L4: reset in the last WAIT cycle, just before the commit edge
        issue(3'b100, 1'b1, 32'h20, 32'h11112222, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 3'b011;
        #1;
        chk_reset_outputs(3'b100, "late_wait_reset");
        repeat (2) @(negedge clk);
        rst_n = 3'b111;
        issue(3'b100, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
